return_stack: RTL and testbench

Hardware return-address stack that sits beside the program counter and acts as its load source. On `call` it captures the current counter value plus one. On `ret` it pops the most recent entry, drives it on `out` and pulses `load`, so the counter jumps back on the following clock edge. It supplies `in`/`load` to the counter; the counter's `out` feeds `pc_in`.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/lifo_mem.sv | 29 ++
 rtl/return_stack.sv | 119 +++++++++++
 tb/tb_return_stack.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the program counter and the return-address stack:
// stack-op encodings for {call, ret} and the default address width.
package cpu_pkg;

  localparam int DEFAULT_BIT_WIDTH = 4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x BIT_WIDTH register array for the return stack: one synchronous
// write port and one combinational read port at the entry below sp (the top).
module lifo_mem #(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [BIT_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        sp,
  output logic [BIT_WIDTH-1:0] top
);

  logic [BIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        raddr;

  // DEPTH is a power of two, so sp-1 wraps naturally to the last slot.
  assign raddr = sp - AW'(1);
  assign top   = mem[raddr];

  // NOTE: storage has no reset; entries are don't-care until written, and
  // leaving the array unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/return_stack.sv
// Return-address stack feeding the program counter's in/load inputs.
// Define RETSTACK_CIRCULAR_EN to make a push when full overwrite the oldest entry.
module return_stack
  import cpu_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] pc_in,
  input  logic                 call,
  input  logic                 ret,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 load,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]        sp;
  logic [CW-1:0]        count;
  logic [1:0]           op;
  logic [BIT_WIDTH-1:0] top;
  logic [BIT_WIDTH-1:0] push_val;
  logic                 we;
  logic [AW-1:0]        waddr;

  assign op       = {call, ret};
  assign push_val = pc_in + BIT_WIDTH'(1);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    we    = 1'b0;
    waddr = sp;
    case (op)
`ifdef RETSTACK_CIRCULAR_EN
      OP_PUSH: we = 1'b1;
`else
      OP_PUSH: we = !full;
`endif
      OP_SWAP: begin
        // A swap on a non-empty stack rewrites the top in place.
        we = 1'b1;
        if (!empty) waddr = sp - AW'(1);
      end
      default: ;
    endcase
  end

  lifo_mem #(
    .BIT_WIDTH(BIT_WIDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(push_val),
    .sp   (sp),
    .top  (top)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '0;
      count <= '0;
      out   <= '0;
      load  <= 1'b0;
      err   <= 1'b0;
    end else begin
      load <= 1'b0;
      case (op)
        OP_PUSH: begin
          if (!full) begin
            sp    <= sp + AW'(1);
            count <= count + CW'(1);
          end else begin
`ifdef RETSTACK_CIRCULAR_EN
            sp <= sp + AW'(1);
`else
            err <= 1'b1;
`endif
          end
        end
        OP_POP: begin
          if (!empty) begin
            out   <= top;
            load  <= 1'b1;
            sp    <= sp - AW'(1);
            count <= count - CW'(1);
          end else begin
            err <= 1'b1;
          end
        end
        OP_SWAP: begin
          if (!empty) begin
            out  <= top;
            load <= 1'b1;
          end else begin
            // Failed pop half; the push half still lands (empty implies not full).
            sp    <= sp + AW'(1);
            count <= count + CW'(1);
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios plus randomized
// traffic compared against a queue-based model of the stack.
module tb_return_stack;

  localparam int BW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] pc_in = '0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [BW-1:0] out;
  logic          load;
  logic          full;
  logic          empty;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the stack is a queue, back of the queue is the top.
  logic [BW-1:0] stk [$];
  logic [BW-1:0] m_out;
  logic          m_load;
  logic          m_err;

  return_stack #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .pc_in(pc_in),
    .call (call),
    .ret  (ret),
    .out  (out),
    .load (load),
    .full (full),
    .empty(empty),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    stk.delete();
    m_out  = '0;
    m_load = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_push(input logic [BW-1:0] pc);
    logic [BW-1:0] v;
    v = pc + 4'd1;
    if (stk.size() < DEPTH) stk.push_back(v);
    else begin
`ifdef RETSTACK_CIRCULAR_EN
      void'(stk.pop_front());
      stk.push_back(v);
`else
      m_err = 1'b1;
`endif
    end
  endtask

  task automatic model_apply(input logic c, input logic r, input logic [BW-1:0] pc);
    m_load = 1'b0;
    if (c && !r) model_push(pc);
    else if (!c && r) begin
      if (stk.size() > 0) begin
        m_out  = stk.pop_back();
        m_load = 1'b1;
      end else m_err = 1'b1;
    end else if (c && r) begin
      if (stk.size() > 0) begin
        m_out  = stk[stk.size()-1];
        m_load = 1'b1;
        stk[stk.size()-1] = pc + 4'd1;
      end else begin
        stk.push_back(pc + 4'd1);
        m_err = 1'b1;
      end
    end
  endtask

  // Drive at the falling edge, let the rising edge act, sample 1 ns later.
  task automatic step(input logic c, input logic r, input logic [BW-1:0] pc);
    @(negedge clk);
    call  = c;
    ret   = r;
    pc_in = pc;
    @(posedge clk);
    model_apply(c, r, pc);
    #1;
  endtask

  task automatic do_reset();
    call  = 1'b0;
    ret   = 1'b0;
    pc_in = '0;
    rst   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b1, 4'd0);  // underflow sets err
    step(1'b1, 1'b0, 4'd3);
    step(1'b1, 1'b0, 4'd7);
    step(1'b0, 1'b1, 4'd0);  // load high now, out = 8
    n_checks++;
    if (load !== 1'b1 || out !== 4'd8 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: load=%b out=%0d err=%b expected load=1 out=8 err=1", load, out, err);
    end
    #2 rst = 1'b0;  // mid-cycle, away from any edge
    #1;
    n_checks++;
    if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b expected 0", load); end
    n_checks++;
    if (out !== 4'd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", out); end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_push_pop_order();
    logic [BW-1:0] pcs [3];
    logic [BW-1:0] exp_o [3];
    pcs   = '{4'd2, 4'd5, 4'd9};
    exp_o = '{4'd10, 4'd6, 4'd3};
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, pcs[i]);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'd0);
      n_checks++;
      if (out !== exp_o[i] || load !== 1'b1) begin
        n_fail++;
        $display("FAIL pop_order[%0d]: out=%0d load=%b expected out=%0d load=1", i, out, load, exp_o[i]);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_order_empty: empty=%b err=%b expected empty=1 err=0", empty, err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 1'b0, 4'hF);
    step(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (out !== 4'h0 || load !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pop: out=%0d load=%b expected out=0 load=1", out, load);
    end
    step(1'b0, 1'b0, 4'd0);
    n_checks++;
    if (load !== 1'b0 || out !== 4'h0) begin
      n_fail++;
      $display("FAIL wrap_strobe: out=%0d load=%b expected out=0 load=0", out, load);
    end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] exp_o [4];
    logic          exp_err;
`ifdef RETSTACK_CIRCULAR_EN
    exp_o   = '{4'd5, 4'd4, 4'd3, 4'd2};
    exp_err = 1'b0;
`else
    exp_o   = '{4'd4, 4'd3, 4'd2, 4'd1};
    exp_err = 1'b1;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, BW'(i));
    n_checks++;
    if (err !== exp_err || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flags: err=%b full=%b expected err=%b full=1", err, full, exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd0);
      n_checks++;
      if (out !== exp_o[i] || load !== 1'b1) begin
        n_fail++;
        $display("FAIL overflow_pop[%0d]: out=%0d load=%b expected out=%0d load=1", i, out, load, exp_o[i]);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_drain: empty=%b full=%b expected empty=1 full=0", empty, full);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b0, 1'b1, 4'd5);
    n_checks++;
    if (load !== 1'b0 || out !== 4'd0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: load=%b out=%0d err=%b expected load=0 out=0 err=1", load, out, err);
    end
    step(1'b1, 1'b0, 4'd2);
    step(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (out !== 4'd3 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_sticky: out=%0d err=%b expected out=3 err=1", out, err);
    end
    step(1'b0, 1'b0, 4'd0);
    n_checks++;
    if (load !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_hold: load=%b err=%b expected load=0 err=1", load, err);
    end
  endtask

  task automatic test_swap();
    do_reset();
    step(1'b1, 1'b0, 4'd6);
    step(1'b1, 1'b1, 4'd11);
    n_checks++;
    if (out !== 4'd7 || load !== 1'b1 || empty !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL swap: out=%0d load=%b empty=%b full=%b expected out=7 load=1 empty=0 full=0",
               out, load, empty, full);
    end
    step(1'b0, 1'b1, 4'd0);
    n_checks++;
    if (out !== 4'd12 || load !== 1'b1 || empty !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pop: out=%0d load=%b empty=%b err=%b expected out=12 load=1 empty=1 err=0",
               out, load, empty, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] p;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      p = BW'($urandom_range(0, 15));
      step(1'b1, 1'b0, p);
      step(1'b0, 1'b1, 4'd0);
      n_checks++;
      if (out !== BW'(p + 4'd1) || load !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: out=%0d load=%b expected out=%0d load=1", i, out, load, BW'(p + 4'd1));
      end
    end
  endtask

  task automatic test_random();
    int            sel;
    logic          c, r;
    logic [BW-1:0] p;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      sel = $urandom_range(0, 9);
      c = (sel < 4) || (sel == 7);
      r = (sel >= 4 && sel < 8);
      p = BW'($urandom_range(0, 15));
      step(c, r, p);
      n_checks++;
      if (out !== m_out || load !== m_load || err !== m_err ||
          full !== (stk.size() == DEPTH) || empty !== (stk.size() == 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%0d load=%b err=%b full=%b empty=%b expected out=%0d load=%b err=%b depth=%0d",
                 i, out, load, err, full, empty, m_out, m_load, m_err, stk.size());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_push_pop_order();
    test_wrap();
    test_overflow();
    test_underflow();
    test_swap();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
